apu_reg_sequencer: RTL and testbench
====================================

// Module: apu_reg_sequencer
// PURPOSE
//  Decodes host UART bytes (nibble protocol) into 8-bit APU square-channel register writes.
//  Queues the writes and drains them onto the APU register port, one write at a time.
//  Never writes in a frame_tick cycle. Pulses apu_trig after every write to the trigger register.
//  Sits between the UART receiver and the APU square channel, inside the chip top.
// PARAMETERS
//  DEPTH     4  write-queue entries; power of 2, >=2
//  TRIG_REG  3  register index whose write restarts the channel (length/sequencer reload)
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous reset, active low
//  rx_data     in   8  received UART byte
//  rx_valid    in   1  one-cycle strobe, rx_data valid
//  flush       in   1  synchronous clear of queue, staging and sticky flags
//  frame_tick  in   1  APU quarter-frame strobe; no apu_we may coincide with it
//  apu_addr    out  2  register index of current write
//  apu_data    out  8  register value of current write
//  apu_we      out  1  one-cycle write strobe
//  apu_trig    out  1  one-cycle pulse, cycle after apu_we when apu_addr==TRIG_REG
//  low_pend    out  4  bit i = low nibble staged for register i
//  proto_err   out  1  sticky: bit7 set, or high nibble with no staged low
//  overflow    out  1  sticky: high nibble arrived with queue full
// BEHAVIOUR
//  - Reset: all outputs 0; queue empty; FSM IDLE; staging cleared.
//  - Byte fields: [7] must be 0; [6:5] idx; [4] hi flag; [3:0] nib.
//  - Byte with bit7=1: dropped; proto_err<=1.
//  - hi=0: stage[idx]<=nib; low_pend[idx]<=1. A repeat overwrites the staged value.
//  - hi=1 with low_pend[idx]=1:
//      - push {idx, nib, stage[idx]}; clear low_pend[idx].
//      - Queue full: entry dropped, overflow<=1, low_pend[idx] still cleared.
//      - The full check uses the post-pop count: push is accepted if a pop happens in the same cycle.
//  - hi=1 with low_pend[idx]=0: dropped; proto_err<=1.
//  - Queue is FIFO order. Occupancy counter width clog2(DEPTH)+1. Read/write pointers wrap modulo DEPTH.
//  - FSM:
//      - IDLE -> WRITE when queue non-empty and frame_tick=0; pop at this transition.
//      - WRITE: apu_we=1 for exactly 1 cycle; apu_addr/apu_data held from the popped entry.
//      - WRITE -> TRIG if addr==TRIG_REG, else -> IDLE.
//      - TRIG: apu_trig=1 for 1 cycle -> IDLE.
//  - apu_addr/apu_data hold their last value outside WRITE.
//  - frame_tick=1 in IDLE: stay IDLE and pop nothing. A WRITE already entered completes regardless.
//  - Latency, empty queue, frame_tick=0: high byte rx_valid at cycle N -> entry at N+1 -> apu_we at N+2.
//      - Back-to-back queued writes: one every 2 cycles, or every 3 when a TRIG is inserted.
//  - flush:
//      - Next cycle: queue empty, low_pend=0, proto_err=0, overflow=0, FSM IDLE, apu_we=apu_trig=0.
//      - flush has priority over a simultaneous rx_valid, which is dropped.
//  - Reset mid-write aborts immediately; no partial strobes after rst_n deasserts.
// STRUCTURE
//  - Package apu_pkg:
//      - field localparams (ERR_BIT=7, IDX_MSB=6, IDX_LSB=5, HI_BIT=4)
//      - typedef enum {IDLE, WRITE, TRIG} seq_state_t
//      - typedef struct packed {logic [1:0] addr; logic [7:0] data;} apu_wr_t
//  - Sub-module apu_wr_fifo (DEPTH x apu_wr_t, push/pop/full/empty/count).
//  - Decoder, staging and FSM stay in this module.
// TESTING
//  - Jump sequence 27,3A,02,18,4C,57,69,70 -> writes (1,A7),(0,82),(2,7C),(3,09) in order.
//      - apu_trig once, in the cycle after (3,09); proto_err=overflow=0.
//  - Lone 3A, then 8F -> no apu_we; proto_err=1; low_pend=0.
//  - frame_tick held 1; send 5 pairs for reg0 = 11,22,33,44,55 -> overflow=1, no apu_we.
//      - Release frame_tick -> exactly 4 writes 11,22,33,44.
//  - frame_tick pulses in the cycle a write would start -> apu_we slips 1 cycle, never coincides.
//  - Send 2B, then flush with 3C coincident -> no write; low_pend=0; flags cleared.
//  - rst_n low during WRITE -> apu_we/apu_trig 0 immediately; queue empty after release.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared field positions, sequencer states and the queued-write record for the
// APU register sequencer and its write queue.
package apu_pkg;

  // Host byte layout: [7] must be zero, [6:5] register index, [4] high-nibble flag, [3:0] nibble
  localparam int ERR_BIT = 7;
  localparam int IDX_MSB = 6;
  localparam int IDX_LSB = 5;
  localparam int HI_BIT  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    TRIG  = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } apu_wr_t;

  localparam int WR_W = $bits(apu_wr_t);

  function automatic apu_wr_t pack_wr(input logic [1:0] idx, input logic [3:0] hi_nib,
                                      input logic [3:0] lo_nib);
    apu_wr_t w_wr;
    w_wr.addr = idx;
    w_wr.data = {hi_nib, lo_nib};
    return w_wr;
  endfunction

endpackage

// File: rtl/apu_wr_fifo.sv
// Small first-in first-out queue of pending APU register writes. The head entry
// is readable combinationally so the sequencer can latch it in the pop cycle.
import apu_pkg::*;

module apu_wr_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WR_W-1:0]          i_wr,
  input  logic                     i_pop,
  output logic [WR_W-1:0]          o_rd,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WR_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  logic w_do_pop;
  logic w_do_push;

  assign w_do_pop  = i_pop && (r_count != '0);
  // A push into a full queue is still accepted when the head leaves in the same cycle
  assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wr;
    end
  end

  assign o_rd    = r_mem[r_rd_ptr];
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/apu_reg_sequencer.sv
// Turns host nibble-protocol bytes into APU square-channel register writes,
// queues them and plays them out one at a time, avoiding quarter-frame ticks.
import apu_pkg::*;

module apu_reg_sequencer #(
  parameter int         DEPTH    = 4,
  parameter logic [1:0] TRIG_REG = 2'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  input  logic       i_flush,
  input  logic       i_frame_tick,
  output logic [1:0] o_apu_addr,
  output logic [7:0] o_apu_data,
  output logic       o_apu_we,
  output logic       o_apu_trig,
  output logic [3:0] o_low_pend,
  output logic       o_proto_err,
  output logic       o_overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  seq_state_t r_state;
  logic [1:0] r_addr;
  logic [7:0] r_data;
  logic [3:0] r_stage [4];
  logic [3:0] r_low_pend;
  logic       r_proto_err;
  logic       r_overflow;

  logic            w_rx_ok;
  logic [1:0]      w_idx;
  logic [3:0]      w_nib;
  logic            w_bad;
  logic            w_lo_wr;
  logic            w_hi_wr;
  logic            w_pair;
  logic            w_orphan;
  logic            w_pop;
  logic            w_push;
  logic            w_ovf;
  logic [CW-1:0]   w_post_pop_cnt;
  apu_wr_t         w_entry;
  apu_wr_t         w_head;
  logic [WR_W-1:0] w_rd;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;

  // flush wins over a coincident byte, so the byte is simply never decoded
  assign w_rx_ok  = i_rx_valid && !i_flush;
  assign w_idx    = i_rx_data[IDX_MSB:IDX_LSB];
  assign w_nib    = i_rx_data[3:0];
  assign w_bad    = w_rx_ok && i_rx_data[ERR_BIT];
  assign w_lo_wr  = w_rx_ok && !i_rx_data[ERR_BIT] && !i_rx_data[HI_BIT];
  assign w_hi_wr  = w_rx_ok && !i_rx_data[ERR_BIT] && i_rx_data[HI_BIT];
  assign w_pair   = w_hi_wr && r_low_pend[w_idx];
  assign w_orphan = w_hi_wr && !r_low_pend[w_idx];
  assign w_entry  = pack_wr(w_idx, w_nib, r_stage[w_idx]);

  assign w_pop          = (r_state == IDLE) && !w_empty && !i_frame_tick && !i_flush;
  assign w_post_pop_cnt = w_count - CW'(w_pop);
  assign w_push         = w_pair && (w_post_pop_cnt < CW'(DEPTH));
  assign w_ovf          = w_pair && w_full && !w_pop;

  apu_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (i_flush),
    .i_push  (w_push),
    .i_wr    (w_entry),
    .i_pop   (w_pop),
    .o_rd    (w_rd),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_head = apu_wr_t'(w_rd);

  // Per-register low-nibble staging; the pending bit clears whether or not the pair was queued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_stage[i] <= '0;
      end
      r_low_pend <= '0;
    end else if (i_flush) begin
      r_low_pend <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_lo_wr && (w_idx == 2'(i))) begin
          r_stage[i]    <= w_nib;
          r_low_pend[i] <= 1'b1;
        end else if (w_pair && (w_idx == 2'(i))) begin
          r_low_pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_proto_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (i_flush) begin
      r_proto_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_proto_err <= r_proto_err | w_bad | w_orphan;
      r_overflow  <= r_overflow | w_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state <= WRITE;
            r_addr  <= w_head.addr;
            r_data  <= w_head.data;
          end
        end
        WRITE:   r_state <= (r_addr == TRIG_REG) ? TRIG : IDLE;
        TRIG:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_apu_addr  = r_addr;
  assign o_apu_data  = r_data;
  assign o_apu_we    = (r_state == WRITE);
  assign o_apu_trig  = (r_state == TRIG);
  assign o_low_pend  = r_low_pend;
  assign o_proto_err = r_proto_err;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_apu_reg_sequencer.sv
// Directed bench: a queue-based model of the sequencer is compared every cycle,
// and each scenario also pins hand-computed writes, cycles and flags.
module tb_apu_reg_sequencer;

  localparam int         DEPTH    = 4;
  localparam logic [1:0] TRIG_REG = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_valid = 1'b0;
  logic       i_flush = 1'b0;
  logic       i_frame_tick = 1'b0;
  logic [1:0] o_apu_addr;
  logic [7:0] o_apu_data;
  logic       o_apu_we;
  logic       o_apu_trig;
  logic [3:0] o_low_pend;
  logic       o_proto_err;
  logic       o_overflow;

  apu_reg_sequencer #(
    .DEPTH    (DEPTH),
    .TRIG_REG (TRIG_REG)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .i_flush      (i_flush),
    .i_frame_tick (i_frame_tick),
    .o_apu_addr   (o_apu_addr),
    .o_apu_data   (o_apu_data),
    .o_apu_we     (o_apu_we),
    .o_apu_trig   (o_apu_trig),
    .o_low_pend   (o_low_pend),
    .o_proto_err  (o_proto_err),
    .o_overflow   (o_overflow)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Behavioural model: pending writes as a plain queue, sequencer as a busy countdown
  logic [9:0] mq[$];
  logic [3:0] m_stage [4];
  logic [3:0] m_lp;
  logic       m_perr, m_ovf, m_we, m_trig;
  logic [1:0] m_addr;
  logic [7:0] m_data;
  int         m_busy;

  logic [9:0] obs[$];
  int         we_cyc[$];
  int         trig_cnt;
  int         last_trig_cyc;
  int         coincide_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 4; i++) m_stage[i] = 4'h0;
    m_lp = 4'h0; m_perr = 1'b0; m_ovf = 1'b0; m_we = 1'b0; m_trig = 1'b0;
    m_addr = 2'd0; m_data = 8'h00; m_busy = 0;
  endtask

  task automatic model_clock();
    logic       pop, next_trig;
    logic [9:0] e;
    logic [1:0] idx;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (i_flush) begin
      mq.delete();
      m_lp = 4'h0; m_perr = 1'b0; m_ovf = 1'b0; m_busy = 0; m_we = 1'b0; m_trig = 1'b0;
      return;
    end
    next_trig = m_we && (m_addr == TRIG_REG);
    pop = (m_busy == 0) && (mq.size() > 0) && !i_frame_tick;
    if (pop) begin
      e = mq.pop_front();
      m_addr = e[9:8];
      m_data = e[7:0];
      m_busy = (e[9:8] == TRIG_REG) ? 2 : 1;
    end else if (m_busy > 0) begin
      m_busy--;
    end
    if (i_rx_valid) begin
      idx = i_rx_data[6:5];
      if (i_rx_data[7]) m_perr = 1'b1;
      else if (!i_rx_data[4]) begin
        m_stage[idx] = i_rx_data[3:0];
        m_lp[idx] = 1'b1;
      end else if (m_lp[idx]) begin
        m_lp[idx] = 1'b0;
        if (mq.size() < DEPTH) mq.push_back({idx, i_rx_data[3:0], m_stage[idx]});
        else m_ovf = 1'b1;
      end else m_perr = 1'b1;
    end
    m_we = pop;
    m_trig = next_trig;
  endtask

  // One cycle: compare at the falling edge, then advance DUT and model on the rising edge
  task automatic step();
    @(negedge clk);
    chk("we", o_apu_we, m_we);
    chk("trig", o_apu_trig, m_trig);
    chk("addr", o_apu_addr, m_addr);
    chk("data", o_apu_data, m_data);
    chk("low_pend", o_low_pend, m_lp);
    chk("proto_err", o_proto_err, m_perr);
    chk("overflow", o_overflow, m_ovf);
    if (o_apu_we) begin
      obs.push_back({o_apu_addr, o_apu_data});
      we_cyc.push_back(cyc);
      if (i_frame_tick) coincide_cnt++;
    end
    if (o_apu_trig) begin
      trig_cnt++;
      last_trig_cyc = cyc;
    end
    @(posedge clk);
    model_clock();
    cyc++;
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_data = b;
    i_rx_valid = 1'b1;
    step();
    i_rx_valid = 1'b0;
    i_rx_data = 8'h00;
  endtask

  task automatic do_flush();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
  endtask

  task automatic clear_obs();
    obs.delete();
    we_cyc.delete();
    trig_cnt = 0;
    last_trig_cyc = -1;
    coincide_cnt = 0;
  endtask

  logic [7:0] jump [8];
  logic [9:0] jump_exp [4];
  logic [7:0] vals [5];
  int         k;

  initial begin
    model_reset();
    clear_obs();
    repeat (2) step();
    rst_n = 1'b1;
    chk("reset_we", o_apu_we, 0);
    chk("reset_low_pend", o_low_pend, 0);
    chk("reset_flags", {o_proto_err, o_overflow, o_apu_trig}, 0);
    step();

    // Jump sequence
    jump = '{8'h27, 8'h3A, 8'h02, 8'h18, 8'h4C, 8'h57, 8'h69, 8'h70};
    jump_exp = '{10'h1A7, 10'h082, 10'h27C, 10'h309};
    clear_obs();
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) k = cyc;
      send(jump[i]);
    end
    repeat (10) step();
    chk("jump_count", obs.size(), 4);
    for (int i = 0; i < obs.size() && i < 4; i++) chk("jump_write", obs[i], jump_exp[i]);
    if (we_cyc.size() == 4) begin
      chk("jump_latency", we_cyc[0], k + 2);
      chk("jump_last_cycle", we_cyc[3], k + 8);
      chk("jump_trig_cycle", last_trig_cyc, we_cyc[3] + 1);
    end
    chk("jump_trig_count", trig_cnt, 1);
    chk("jump_flags", {o_proto_err, o_overflow}, 0);

    // Orphan high nibble and a bit-7 byte
    do_flush();
    clear_obs();
    send(8'h3A);
    send(8'h8F);
    repeat (4) step();
    chk("orphan_no_write", obs.size(), 0);
    chk("orphan_proto_err", o_proto_err, 1);
    chk("orphan_low_pend", o_low_pend, 0);

    // Queue overflow while frame_tick holds the sequencer off
    do_flush();
    chk("flush_clears_err", o_proto_err, 0);
    clear_obs();
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    i_frame_tick = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send({4'h0, vals[i][3:0]});
      send({4'h1, vals[i][7:4]});
    end
    repeat (3) step();
    chk("ovf_flag", o_overflow, 1);
    chk("ovf_no_write", obs.size(), 0);
    i_frame_tick = 1'b0;
    repeat (12) step();
    chk("ovf_write_count", obs.size(), 4);
    for (int i = 0; i < obs.size() && i < 4; i++) chk("ovf_write", obs[i], {2'd0, vals[i]});

    // frame_tick in the pop cycle delays the write by one cycle
    do_flush();
    clear_obs();
    send(8'h0A);
    i_rx_data = 8'h1B;
    i_rx_valid = 1'b1;
    k = cyc;
    step();
    i_rx_valid = 1'b0;
    i_frame_tick = 1'b1;
    step();
    i_frame_tick = 1'b0;
    repeat (4) step();
    chk("slip_count", obs.size(), 1);
    if (we_cyc.size() > 0) chk("slip_cycle", we_cyc[0], k + 3);
    if (obs.size() > 0) chk("slip_write", obs[0], 10'h0BA);
    chk("slip_no_coincide", coincide_cnt, 0);

    // flush beats a coincident high nibble
    do_flush();
    clear_obs();
    send(8'h80);
    send(8'h2B);
    i_flush = 1'b1;
    i_rx_data = 8'h3C;
    i_rx_valid = 1'b1;
    step();
    i_flush = 1'b0;
    i_rx_valid = 1'b0;
    repeat (4) step();
    chk("flushrx_no_write", obs.size(), 0);
    chk("flushrx_low_pend", o_low_pend, 0);
    chk("flushrx_flags", {o_proto_err, o_overflow}, 0);

    // Push into a full queue is accepted when a pop happens in the same cycle
    do_flush();
    clear_obs();
    i_frame_tick = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      send(8'(i));
      send(8'h10);
    end
    send(8'h27);
    i_frame_tick = 1'b0;
    send(8'h3A);
    chk("popush_no_ovf", o_overflow, 0);
    repeat (12) step();
    chk("popush_count", obs.size(), 5);
    if (obs.size() == 5) chk("popush_last", obs[4], 10'h1A7);

    // Reset asserted in the middle of a write
    do_flush();
    clear_obs();
    i_frame_tick = 1'b1;
    send(8'h69);
    send(8'h70);
    send(8'h69);
    send(8'h71);
    i_frame_tick = 1'b0;
    step();
    chk("rst_pre_we", o_apu_we, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_we_now", o_apu_we, 0);
    chk("rst_trig_now", o_apu_trig, 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (8) step();
    chk("rst_no_write", obs.size(), 0);
    chk("rst_no_trig", trig_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
